// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one write port, and a debug dump port.
// Define REGFILE_BYPASS_EN to return same-cycle write data on matching reads.
module regfile #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  input  logic          dbg_req,
  input  logic          dbg_ready,
  output logic          dbg_valid,
  output logic [AW-1:0] dbg_idx,
  output logic [DW-1:0] dbg_data,
  output logic          dbg_busy,
  output logic          dbg_done
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW-1:0] LastIdx = AW'(Depth - 1);

  typedef enum logic [1:0] {StIdle, StDump, StDone} state_e;

  logic [DW-1:0] mem_q [Depth];

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (re1 && (raddr1 != '0)) begin
      rdata1 = mem_q[raddr1];
`ifdef REGFILE_BYPASS_EN
      if (we && (waddr == raddr1)) rdata1 = wdata;
`endif
    end
  end

  always_comb begin
    rdata2 = '0;
    if (re2 && (raddr2 != '0)) begin
      rdata2 = mem_q[raddr2];
`ifdef REGFILE_BYPASS_EN
      if (we && (waddr == raddr2)) rdata2 = wdata;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dbg_req) begin
          state_d = StDump;
          idx_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StDump: begin
        if (valid_q && dbg_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Dump reads storage directly; the write-back bypass never applies here.
  assign dbg_data  = (valid_q && (idx_q != '0)) ? mem_q[idx_q] : '0;
  assign dbg_valid = valid_q;
  assign dbg_idx   = idx_q;
  assign dbg_busy  = busy_q;
  assign dbg_done  = done_q;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reads, writes, bypass, dump, backpressure, reset.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;
  logic        dbg_req = 1'b0;
  logic        dbg_ready = 1'b0;
  logic        dbg_valid;
  logic [4:0]  dbg_idx;
  logic [31:0] dbg_data;
  logic        dbg_busy;
  logic        dbg_done;

  int checks = 0;
  int failures = 0;

  regfile #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .dbg_req(dbg_req), .dbg_ready(dbg_ready), .dbg_valid(dbg_valid),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data), .dbg_busy(dbg_busy), .dbg_done(dbg_done)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; checks happen 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    settle();
    checks++;
    if ({dbg_valid, dbg_busy, dbg_done, dbg_idx, dbg_data} !== '0) begin
      failures++;
      $display("FAIL reset_dbg: got valid=%b busy=%b done=%b idx=%0d data=%h, expected all 0",
               dbg_valid, dbg_busy, dbg_done, dbg_idx, dbg_data);
    end
    rst = 1'b1;
    tick();
    write_reg(5'd5, 32'hCAFE_0005);
    re1 = 1'b1; raddr1 = 5'd5;
    settle();
    checks++;
    if (rdata1 !== 32'hCAFE_0005) begin
      failures++;
      $display("FAIL pre_reset_read: got %h expected %h", rdata1, 32'hCAFE_0005);
    end
    rst = 1'b0;
    settle();
    rst = 1'b1;
    tick();
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_read5: got %h expected 00000000", rdata1);
    end
    checks++;
    if ({dbg_valid, dbg_busy, dbg_done, dbg_idx, dbg_data} !== '0) begin
      failures++;
      $display("FAIL reset_dbg2: got valid=%b busy=%b done=%b idx=%0d data=%h, expected all 0",
               dbg_valid, dbg_busy, dbg_done, dbg_idx, dbg_data);
    end
    re1 = 1'b0;
  endtask

  task automatic test_write_read();
    write_reg(5'd3, 32'h1234_5678);
    re2 = 1'b1; raddr2 = 5'd3;
    settle();
    checks++;
    if (rdata2 !== 32'h1234_5678) begin
      failures++;
      $display("FAIL read3_port2: got %h expected 12345678", rdata2);
    end
    write_reg(5'd0, 32'hFFFF_FFFF);
    re1 = 1'b1; raddr1 = 5'd0;
    settle();
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL read0: got %h expected 00000000", rdata1);
    end
    raddr1 = 5'd3;
    re2 = 1'b0;
    settle();
    checks++;
    if (rdata1 !== 32'h1234_5678 || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL read3_p1_re2off: got p1=%h p2=%h expected 12345678 00000000", rdata1, rdata2);
    end
    re1 = 1'b0;
  endtask

  task automatic test_bypass();
    logic [31:0] exp1;
`ifdef REGFILE_BYPASS_EN
    exp1 = 32'hA5A5_A5A5;
`else
    exp1 = 32'h0000_0001;
`endif
    write_reg(5'd7, 32'h1);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
    re1 = 1'b1; raddr1 = 5'd7;
    re2 = 1'b0; raddr2 = 5'd7;
    settle();
    checks++;
    if (rdata1 !== exp1) begin
      failures++;
      $display("FAIL bypass_same_cycle: got %h expected %h", rdata1, exp1);
    end
    checks++;
    if (rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL bypass_re2_off: got %h expected 00000000", rdata2);
    end
    tick();
    we = 1'b0;
    re2 = 1'b1;
    settle();
    checks++;
    if (rdata1 !== 32'hA5A5_A5A5 || rdata2 !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL read7_after: got p1=%h p2=%h expected a5a5a5a5 both", rdata1, rdata2);
    end
    re1 = 1'b0; re2 = 1'b0;
  endtask

  task automatic preload();
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i * 32'h11));
  endtask

  task automatic test_full_dump();
    int bad = 0;
    preload();
    dbg_ready = 1'b1;
    dbg_req = 1'b1;
    tick();
    dbg_req = 1'b0;
    for (int b = 0; b < 32; b++) begin
      settle();
      if (dbg_valid !== 1'b1 || dbg_busy !== 1'b1 || dbg_done !== 1'b0 ||
          dbg_idx !== 5'(b) || dbg_data !== 32'(b * 32'h11)) begin
        bad++;
        $display("FAIL dump_beat%0d: got valid=%b busy=%b done=%b idx=%0d data=%h expected 1 1 0 %0d %h",
                 b, dbg_valid, dbg_busy, dbg_done, dbg_idx, dbg_data, b, 32'(b * 32'h11));
      end
      tick();
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (dbg_done !== 1'b1 || dbg_valid !== 1'b0) begin
      failures++;
      $display("FAIL dump_done_at33: got done=%b valid=%b expected done=1 valid=0", dbg_done, dbg_valid);
    end
    tick();
    checks++;
    if (dbg_done !== 1'b0 || dbg_busy !== 1'b0 || dbg_valid !== 1'b0) begin
      failures++;
      $display("FAIL dump_idle_after: got done=%b busy=%b valid=%b expected 0 0 0",
               dbg_done, dbg_busy, dbg_valid);
    end
  endtask

  task automatic test_backpressure();
    int done_cnt = 0;
    int done_cyc = -1;
    int cyc;
    dbg_ready = 1'b1;
    dbg_req = 1'b1;
    tick();
    dbg_req = 1'b0;
    repeat (4) tick();
    // Cycle 5: index 4 presented; stall, collide a write, and issue a stray request.
    dbg_ready = 1'b0;
    we = 1'b1; waddr = 5'd4; wdata = 32'h0000_DEAD;
    dbg_req = 1'b1;
    settle();
    checks++;
    if (dbg_idx !== 5'd4 || dbg_data !== 32'h44) begin
      failures++;
      $display("FAIL stall_start: got idx=%0d data=%h expected 4 00000044", dbg_idx, dbg_data);
    end
    tick();
    we = 1'b0; dbg_req = 1'b0;
    settle();
    checks++;
    if (dbg_idx !== 5'd4 || dbg_valid !== 1'b1 || dbg_data !== 32'h0000_DEAD) begin
      failures++;
      $display("FAIL stall_write: got idx=%0d valid=%b data=%h expected 4 1 0000dead",
               dbg_idx, dbg_valid, dbg_data);
    end
    tick();
    tick();
    checks++;
    if (dbg_idx !== 5'd4 || dbg_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_hold: got idx=%0d valid=%b expected 4 1", dbg_idx, dbg_valid);
    end
    dbg_ready = 1'b1;
    cyc = 8;
    for (int k = 0; k < 60; k++) begin
      tick();
      cyc++;
      if (dbg_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 36) begin
      failures++;
      $display("FAIL stall_done: got pulses=%0d at cycle %0d expected 1 at 36", done_cnt, done_cyc);
    end
  endtask

  task automatic test_reset_mid_dump();
    int done_cnt = 0;
    dbg_ready = 1'b1;
    dbg_req = 1'b1;
    tick();
    dbg_req = 1'b0;
    repeat (10) tick();
    checks++;
    if (dbg_idx !== 5'd10 || dbg_valid !== 1'b1) begin
      failures++;
      $display("FAIL middump_pos: got idx=%0d valid=%b expected 10 1", dbg_idx, dbg_valid);
    end
    rst = 1'b0;
    settle();
    checks++;
    if (dbg_valid !== 1'b0 || dbg_busy !== 1'b0 || dbg_idx !== 5'd0 || dbg_done !== 1'b0) begin
      failures++;
      $display("FAIL middump_reset: got valid=%b busy=%b idx=%0d done=%b expected 0 0 0 0",
               dbg_valid, dbg_busy, dbg_idx, dbg_done);
    end
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (dbg_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL middump_nodone: got %0d done pulses expected 0", done_cnt);
    end
    dbg_req = 1'b1;
    tick();
    dbg_req = 1'b0;
    checks++;
    if (dbg_valid !== 1'b1 || dbg_busy !== 1'b1 || dbg_idx !== 5'd0 || dbg_data !== 32'h0) begin
      failures++;
      $display("FAIL restart: got valid=%b busy=%b idx=%0d data=%h expected 1 1 0 00000000",
               dbg_valid, dbg_busy, dbg_idx, dbg_data);
    end
    tick();
    checks++;
    if (dbg_idx !== 5'd1 || dbg_data !== 32'h0) begin
      failures++;
      $display("FAIL restart_beat1: got idx=%0d data=%h expected 1 00000000", dbg_idx, dbg_data);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (dbg_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL restart_done: got %0d done pulses expected 1", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_full_dump();
    test_backpressure();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the five-stage MIPS pipeline, serving the two decode-stage read ports and accepting the single write-back write port. It has 32 × 32-bit registers, with `$0` hardwired to zero. A compile-time write-through bypass lets a read in the same cycle as a write-back see the new value. A handshaked debug dump port streams all 32 registers to a bench or debug host without stalling the pipeline.

## Interface
Parameters:
- `DW`, 32, register width in bits.
- `AW`, 5, register address width; depth is `2**AW`, which is 32.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `we`  in  1  write-back write enable.
- `waddr`  in  AW  write-back destination register.
- `wdata`  in  DW  write-back data.
- `re1`  in  1  read port 1 enable, driven by decode.
- `raddr1`  in  AW  read port 1 address.
- `rdata1`  out  DW  read port 1 data, combinational.
- `re2`  in  1  read port 2 enable.
- `raddr2`  in  AW  read port 2 address.
- `rdata2`  out  DW  read port 2 data, combinational.
- `dbg_req`  in  1  one-cycle pulse that starts a dump.
- `dbg_ready`  in  1  consumer accepts the current dump beat.
- `dbg_valid`  out  1  dump beat valid.
- `dbg_idx`  out  AW  register index of the current beat.
- `dbg_data`  out  DW  contents of register `dbg_idx`.
- `dbg_busy`  out  1  dump in progress.
- `dbg_done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
Write:
- On a rising edge with `we`=1 and `waddr`≠0, `wdata` is stored.
- Writes to `$0` are discarded.

Read, evaluated independently per port n:
- `ren`=0 → `rdatan`=0.
- `raddrn`=0 → 0.
- Bypass match, `we`=1 and `waddr`==`raddrn` (≠0) → `wdata` (only with bypass compiled in).
- Otherwise → the stored value.
- Both ports may read the same address in the same cycle.

Dump FSM, states `IDLE`, `DUMP`, `DONE`:
- `IDLE`:
  - `dbg_req`=1 → `DUMP`, with `dbg_idx`←0, `dbg_valid`←1, `dbg_busy`←1.
- `DUMP`:
  - `dbg_data` = stored value of `dbg_idx`; no bypass, and index 0 reads 0.
  - On `dbg_valid`&&`dbg_ready`, if `dbg_idx`<31 then `dbg_idx`++.
  - If `dbg_idx`==31 → `DONE`, with `dbg_valid`←0.
  - If `dbg_ready`=0, `dbg_idx` and `dbg_valid` hold. `dbg_data` follows any write landing on that index.
- `DONE`:
  - `dbg_done`=1 for one cycle, `dbg_busy`←0 → `IDLE`.
- `dbg_req` received in `DUMP` or `DONE` is ignored; it is not queued.
- Pipeline reads and writes are never blocked by the dump.

Reset (`rst`=0, asynchronous):
- All 32 registers clear to 0.
- FSM goes to `IDLE`.
- `dbg_valid`=0, `dbg_idx`=0, `dbg_busy`=0, `dbg_done`=0.
- Combinational read outputs evaluate to 0 because storage is 0.
- A dump in progress is abandoned without a `dbg_done` pulse.

## Timing
- Read latency is 0 cycles (combinational from address, enable and storage).
- Write latency is 1 edge.
- Without bypass, a value written at edge k is readable after edge k.
- With bypass, the value is readable in the same cycle as the write.
- A dump takes at least 33 cycles from `dbg_req`: 32 accepted beats plus one `DONE` cycle. Each cycle with `dbg_ready`=0 adds one.
- Minimum gap between `dbg_done` and the next accepted `dbg_req` is 1 cycle, since `IDLE` is re-entered after `DONE`.
- Dump outputs are registered; `dbg_data` is a combinational read of the `dbg_idx` entry.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - The write-through bypass is present on both read ports.
  - The decode stage then needs no separate write-back forwarding path.
- Not defined:
  - Reads return stored values only.
  - Same-cycle write-back to a read address returns the old value.
  - Decode sees the new value one cycle later.
- The dump port never uses bypass in either configuration.

## Test plan
- Reset then read: assert `rst`=0 mid-run, release, read `$5` with `re1`=1 → `rdata1`=0x00000000. All dump outputs are 0.
- Write/read and `$0` protection:
  - Write `$3`=0x12345678, next cycle read on port 2 → 0x12345678.
  - Write `$0`=0xFFFFFFFF, then read `$0` → 0.
- Same-cycle bypass: `we`=1, `waddr`=7, `wdata`=0xA5A5A5A5, `raddr1`=7, `re1`=1, with `$7` previously 0x1.
  - `rdata1`=0xA5A5A5A5 with `REGFILE_BYPASS_EN`.
  - `rdata1`=0x00000001 without it.
  - Read with `re2`=0 at address 7 → 0.
- Full dump, `dbg_ready` held at 1, registers preloaded with `$i`=i×0x11:
  - 32 beats with `dbg_idx` 0…31 and `dbg_data` 0, 0x11 … 0x20F.
  - `dbg_done` pulses exactly 33 cycles after `dbg_req`.
- Backpressure and collision:
  - Hold `dbg_ready`=0 for 3 cycles at index 4 → `dbg_idx` stays 4.
  - Write `$4`=0xDEAD during the stall → `dbg_data` shows 0xDEAD the cycle after the write.
  - A second `dbg_req` during the dump is ignored and produces only one `dbg_done`.
- Reset mid-dump: pull `rst` low at beat 10 → `dbg_valid`, `dbg_busy` and `dbg_idx` drop to 0 immediately, with no `dbg_done` pulse. A fresh `dbg_req` after release restarts the dump at index 0.
